// File: rtl/wide_add_scheduler_pkg.sv
// Shared definitions for the wide adder scheduler: FSM states, default
// geometry and the requester-id width.
package wide_add_scheduler_pkg;

  localparam int DEF_W      = 16;
  localparam int DEF_NWORDS = 4;
  localparam int ID_W       = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/add16_core.sv
// W-bit adder slice with registered sum and carry-out. One slice is issued
// per cycle and its result is visible the cycle after issue.
module add16_core #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] sum_q;
  logic         cout_q;
  logic [W:0]   total;

  assign total = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

  // Register the slice sum and its carry-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= total[W-1:0];
      cout_q <= total[W];
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/wide_add_scheduler.sv
// Two-requester wide adder. A round-robin arbiter picks one request, whose
// NWORDS*W-bit operands are summed slice by slice (LSB first) through one
// shared registered W-bit adder. The result is held until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is only ever high in IDLE and never for both
// requesters; rsp_valid stays high with stable rsp_* until rsp_ready is seen.
module wide_add_scheduler
  import wide_add_scheduler_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [NWORDS*W-1:0]   req_a0,
  input  logic [NWORDS*W-1:0]   req_b0,
  input  logic                  req_cin0,
  input  logic [NWORDS*W-1:0]   req_a1,
  input  logic [NWORDS*W-1:0]   req_b1,
  input  logic                  req_cin1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [NWORDS*W-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output state_e                dbg_state
);

  localparam int OW = NWORDS * W;
  localparam int CW = $clog2(NWORDS + 1);
  // RUN spends NWORDS cycles issuing slices plus one to capture the last result.
  localparam logic [CW-1:0] LAST = CW'(NWORDS);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            cin_q, cin_d, cout_q, cout_d, rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] id_q, id_d;

  logic            grant, grant_id;
  logic [W-1:0]    add_a, add_b, core_sum;
  logic            add_cin, core_cout;

  // Round-robin arbitration: the pointed-to requester has priority, a lone
  // valid requester always wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = ptr_q;
    if (state_q == ST_IDLE) begin
      if (req_valid[ptr_q]) begin
        grant    = 1'b1;
        grant_id = ptr_q;
      end else if (req_valid[~ptr_q]) begin
        grant    = 1'b1;
        grant_id = ~ptr_q;
      end
    end
    req_ready = grant ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  end

  // Present slice cnt_q to the shared adder; later slices chain the
  // registered carry of the previous slice.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ST_RUN && cnt_q != LAST) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (cnt_q == CW'(k)) begin
          add_a = a_q[k*W +: W];
          add_b = b_q[k*W +: W];
        end
      end
      add_cin = (cnt_q == '0) ? cin_q : core_cout;
    end
  end

  add16_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (core_sum),
    .cout_o (core_cout)
  );

  // FSM next state, operand capture and result assembly.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          a_d     = grant_id ? req_a1 : req_a0;
          b_d     = grant_id ? req_b1 : req_b0;
          cin_d   = grant_id ? req_cin1 : req_cin0;
          id_d    = grant_id;
          ptr_d   = ~grant_id;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // The adder output now holds the result of slice cnt_q-1.
        for (int k = 0; k < NWORDS; k++) begin
          if (cnt_q == CW'(k + 1)) sum_d[k*W +: W] = core_sum;
        end
        if (cnt_q == LAST) begin
          cout_d      = core_cout;
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign dbg_state = state_q;

endmodule

// File: doc/wide_add_scheduler.md
WIDE_ADD_SCHEDULER -- requirements
Module: wide_add_scheduler

Interface
REQ-001 Parameter W, default 16: width of the shared adder slice in bits.
REQ-002 Parameter NWORDS, default 4: slices per operand; operand width is NWORDS*W.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 req_valid  input  2  per-requester request-valid strobe.
REQ-006 req_ready  output  2  per-requester accept; at most one bit high at a time.
REQ-007 req_a0, req_b0  input  NWORDS*W  requester-0 operands.
REQ-008 req_cin0  input  1  requester-0 carry-in.
REQ-009 req_a1, req_b1  input  NWORDS*W  requester-1 operands.
REQ-010 req_cin1  input  1  requester-1 carry-in.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_id  output  1  requester that owns the result.
REQ-014 rsp_sum  output  NWORDS*W  wide sum.
REQ-015 rsp_cout  output  1  carry-out of the most significant slice.

Function
REQ-016 FSM states are IDLE, RUN and RESP; reset state is IDLE.
REQ-017 In IDLE, the requester selected by the round-robin arbiter among valid requesters gets req_ready high; transfer occurs when valid and ready are both high.
REQ-018 Arbiter pointer resets to requester 0; after each grant it points to the other requester; a lone valid requester always wins.
REQ-019 On transfer at cycle T, operands, cin and id are latched and the FSM goes to RUN; req_ready is low outside IDLE.
REQ-020 In RUN, slice k (LSB first) enters the shared 1-cycle registered adder at cycle T+1+k; slice 0 uses the latched cin, and slice k>0 uses the registered carry-out of slice k-1.
REQ-021 Each slice result is written into the sum register at bit offset k*W one cycle after issue.
REQ-022 After the last slice result is captured, the FSM goes to RESP; rsp_valid rises at cycle T+NWORDS+1, for a latency of NWORDS+1.
REQ-023 In RESP, rsp_sum, rsp_cout and rsp_id hold stable while rsp_ready is low.
REQ-024 On rsp_valid&&rsp_ready, the FSM returns to IDLE; a new grant is possible the following cycle, with no same-cycle bypass.
REQ-025 Arithmetic is modulo 2^(NWORDS*W); the carry ripples across slices exactly as in a full-width add.
REQ-026 Request inputs are ignored outside IDLE; a requester dropping valid before grant is legal.

Reset
REQ-027 rst forces, with immediate asynchronous effect: state=IDLE, pointer=0, slice counter=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, carry register=0, adder registers=0.
REQ-028 rst asserted mid-RUN or in RESP discards the operation with no response.
REQ-029 After rst deasserts, the first request is processed correctly.

Structure
REQ-030 A shared package holds the FSM state enum, the default W/NWORDS constants and the requester-id width.
REQ-031 The adder slice is a sub-module add16_core (W-bit, registered sum and cout, clk/rst).
REQ-032 The arbiter, FSM and slice sequencing stay in wide_add_scheduler.

Verification (NWORDS=4, W=16)
REQ-033 Req0 A=0x0000_0000_0000_FFFF, B=0x1, cin=0 at T -> rsp_valid at T+5, sum=0x0000_0000_0001_0000, cout=0, id=0.
REQ-034 Req1 A=B=0xFFFF_FFFF_FFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=1, id=1.
REQ-035 Req0 A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1, proving the carry crosses all slices.
REQ-036 Both req_valid held high continuously with rsp_ready=1 -> grant order 0,1,0,1 and responses with ids 0,1,0,1.
REQ-037 rsp_ready held low 3 cycles in RESP -> outputs stable and req_ready=00 throughout; IDLE the cycle after acceptance.
REQ-038 rst pulsed at T+2 of an operation -> no rsp_valid; the next request 0x1+0x1, cin=0 -> sum=0x2, cout=0, latency 5.
